// File: rtl/instr_sequencer.sv
// instr_sequencer: runs a loaded program and issues opcode/operand pairs over valid/ready
module instr_sequencer #(
    parameter int OP_WIDTH   = 4,
    parameter int REP_WIDTH  = 4,
    parameter int ARG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        prog_we,
    input  logic [ADDR_WIDTH-1:0]                       prog_addr,
    input  logic [OP_WIDTH+REP_WIDTH+ARG_WIDTH-1:0]     prog_wdata,
    input  logic [ADDR_WIDTH:0]                         prog_len,
    input  logic                                        start,
    input  logic                                        issue_ready,
    output logic [OP_WIDTH-1:0]                         opcode_out,
    output logic [ARG_WIDTH-1:0]                        operand_out,
    output logic                                        issue_valid,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        err
);
    localparam int W = OP_WIDTH + REP_WIDTH + ARG_WIDTH;

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_t;

    state_t                 state;
    logic [W-1:0]           mem [2**ADDR_WIDTH];
    logic [W-1:0]           word;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [ADDR_WIDTH:0]    len;
    logic [ADDR_WIDTH:0]    pc_adv;
    logic [REP_WIDTH-1:0]   rep_cnt;
    logic [OP_WIDTH-1:0]    w_op;
    logic [REP_WIDTH-1:0]   w_rep;
    logic [ARG_WIDTH-1:0]   w_arg;
    logic                   last;
    logic                   adv;

    assign w_op    = word[W-1 -: OP_WIDTH];
    assign w_rep   = word[ARG_WIDTH +: REP_WIDTH];
    assign w_arg   = word[ARG_WIDTH-1:0];
    assign pc_adv  = {1'b0, pc} + (ADDR_WIDTH+1)'(1);
    assign last    = pc_adv == len;
    // The read is launched on the edge that enters FETCH, so address the pc that FETCH will see.
    assign rd_addr = (state == IDLE) ? '0 : pc_adv[ADDR_WIDTH-1:0];
    // An instruction retires on an undefined opcode, the final handshake, or the last wait cycle.
    assign adv = (state == FETCH && w_op[OP_WIDTH-1] && !(&w_op)) ||
                 (state == ISSUE && issue_ready && rep_cnt == '0) ||
                 (state == WAIT && rep_cnt == '0);

    // Program memory: host writes only while idle, synchronous read into the fetch word.
    always_ff @(posedge clk) begin
        if (prog_we && !busy) mem[prog_addr] <= prog_wdata;
        word <= mem[rd_addr];
    end

    // Sequencer state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            len         <= '0;
            rep_cnt     <= '0;
            opcode_out  <= '0;
            operand_out <= '0;
            issue_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    len   <= prog_len;
                    pc    <= '0;
                    err   <= 1'b0;
                    busy  <= 1'b1;
                    done  <= prog_len == '0;
                    state <= (prog_len == '0) ? DONE : FETCH;
                end
                FETCH: begin
                    rep_cnt <= w_rep;
                    if (!w_op[OP_WIDTH-1]) begin
                        state       <= ISSUE;
                        opcode_out  <= w_op;
                        operand_out <= w_arg;
                        issue_valid <= 1'b1;
                    end else if (&w_op) state <= WAIT;
                    else err <= 1'b1;
                end
                ISSUE: if (issue_ready && rep_cnt != '0) begin
                    rep_cnt     <= rep_cnt - REP_WIDTH'(1);
                    operand_out <= operand_out + ARG_WIDTH'(1);
                end
                WAIT: rep_cnt <= rep_cnt - REP_WIDTH'(1);
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (adv) begin
                pc          <= pc_adv[ADDR_WIDTH-1:0];
                state       <= last ? DONE : FETCH;
                done        <= last;
                issue_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench for the instruction sequencer
module tb_instr_sequencer;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        prog_we = 0;
    logic [4:0]  prog_addr = '0;
    logic [15:0] prog_wdata = '0;
    logic [5:0]  prog_len = '0;
    logic        start = 0;
    logic        issue_ready = 1;
    logic [3:0]  opcode_out;
    logic [7:0]  operand_out;
    logic        issue_valid, busy, done, err;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] arg;
        int         c;
    } issue_t;

    issue_t exp_q[$];
    int     done_q[$];
    issue_t e;
    int     d;
    int     cyc = 0;
    int     base = 0;
    int     checks = 0;
    int     errors = 0;

    instr_sequencer dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .prog_len(prog_len), .start(start),
        .issue_ready(issue_ready), .opcode_out(opcode_out), .operand_out(operand_out),
        .issue_valid(issue_valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Cycle counter used to timestamp observed events relative to the start edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every handshake and every done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && issue_valid && issue_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected got op=%h arg=%h cycle=%0d want none", opcode_out, operand_out, cyc - base + 1);
            end else begin
                e = exp_q.pop_front();
                if (opcode_out !== e.op || operand_out !== e.arg || cyc - base + 1 != e.c) begin
                    errors++;
                    $display("FAIL issue got op=%h arg=%h cycle=%0d want op=%h arg=%h cycle=%0d",
                             opcode_out, operand_out, cyc - base + 1, e.op, e.arg, e.c);
                end
            end
        end
        if (rst_n && done) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected got cycle=%0d want none", cyc - base + 1);
            end else begin
                d = done_q.pop_front();
                if (cyc - base + 1 != d) begin
                    errors++;
                    $display("FAIL done_cycle got %0d want %0d", cyc - base + 1, d);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] a, input logic [15:0] w);
        tick();
        prog_we = 1; prog_addr = a; prog_wdata = w;
        tick();
        prog_we = 0;
    endtask

    task automatic push(input logic [3:0] op, input logic [7:0] arg, input int c);
        exp_q.push_back('{op: op, arg: arg, c: c});
    endtask

    task automatic go(input logic [5:0] n);
        tick();
        prog_len = n; start = 1;
        tick();
        start = 0;
        base = cyc;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 60) begin
            tick();
            k++;
        end
        check({name, "_done_seen"}, {31'd0, done}, 32'd1);
        check({name, "_busy_in_done"}, {31'd0, busy}, 32'd1);
        tick();
        check({name, "_busy_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        repeat (2) tick();
        check("reset_outputs", {14'd0, opcode_out, operand_out, issue_valid, busy, done, err}, 32'd0);
        rst_n = 1;

        // basic: ADD rep 2 operand 0x10
        load(5'd0, 16'h0210);
        push(4'h0, 8'h10, 2); push(4'h0, 8'h11, 3); push(4'h0, 8'h12, 4);
        done_q.push_back(5);
        go(6'd1);
        wait_done("basic");

        // stall three cycles at the second issue
        push(4'h0, 8'h10, 2); push(4'h0, 8'h11, 6); push(4'h0, 8'h12, 7);
        done_q.push_back(8);
        go(6'd1);
        tick();
        tick();
        issue_ready = 0;
        for (int i = 0; i < 3; i++) begin
            check("stall_hold", {23'd0, issue_valid, operand_out}, {24'd1, 8'h11});
            tick();
        end
        issue_ready = 1;
        wait_done("stall");

        // operand wrap
        load(5'd0, 16'h12FE);
        push(4'h1, 8'hFE, 2); push(4'h1, 8'hFF, 3); push(4'h1, 8'h00, 4);
        done_q.push_back(5);
        go(6'd1);
        wait_done("wrap");

        // ADD, NOP rep 3, MUL
        load(5'd0, 16'h0001); load(5'd1, 16'hF300); load(5'd2, 16'h2005);
        push(4'h0, 8'h01, 2); push(4'h2, 8'h05, 9);
        done_q.push_back(10);
        go(6'd3);
        wait_done("nop");

        // undefined opcode then sigmoid
        load(5'd0, 16'h9000); load(5'd1, 16'h5000);
        push(4'h5, 8'h00, 3);
        done_q.push_back(4);
        go(6'd2);
        tick();
        check("err_set", {31'd0, err}, 32'd1);
        wait_done("err");
        check("err_sticky", {31'd0, err}, 32'd1);

        // zero-length program clears err and finishes in cycle 1
        done_q.push_back(1);
        go(6'd0);
        check("err_cleared", {31'd0, err}, 32'd0);
        wait_done("len0");

        // writes while busy are dropped
        load(5'd0, 16'h0210);
        push(4'h0, 8'h10, 2); push(4'h0, 8'h11, 3); push(4'h0, 8'h12, 4);
        done_q.push_back(5);
        go(6'd1);
        prog_we = 1; prog_addr = 5'd0; prog_wdata = 16'h7777;
        tick();
        tick();
        prog_we = 0;
        wait_done("we_busy_run");
        push(4'h0, 8'h10, 2); push(4'h0, 8'h11, 3); push(4'h0, 8'h12, 4);
        done_q.push_back(5);
        go(6'd1);
        wait_done("we_busy_rerun");

        // reset mid-issue, then rerun
        issue_ready = 0;
        go(6'd1);
        tick();
        check("issue_pending", {31'd0, issue_valid}, 32'd1);
        rst_n = 0;
        tick();
        check("midreset_outputs", {14'd0, opcode_out, operand_out, issue_valid, busy, done, err}, 32'd0);
        rst_n = 1;
        issue_ready = 1;
        push(4'h0, 8'h10, 2); push(4'h0, 8'h11, 3); push(4'h0, 8'h12, 4);
        done_q.push_back(5);
        go(6'd1);
        wait_done("rerun");

        tick();
        check("scoreboard_empty", exp_q.size() + done_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
